// File: rtl/toy_pack.sv
// Shared LSU types: store/bus request payload, bus opcodes, store queue depth.
// Pure declarations, no logic; no latency or backpressure of its own.
package toy_pack;

    localparam int STU_DEPTH = 8;

    typedef enum logic [1:0] {
        TOY_BUS_IDLE   = 2'd0,
        TOY_BUS_READ   = 2'd1,
        TOY_BUS_WRITE  = 2'd2,
        TOY_BUS_ATOMIC = 2'd3
    } toy_bus_op_e;

    typedef struct packed {
        toy_bus_op_e mem_req_opcode;
        logic [31:0] mem_req_addr;
        logic [31:0] mem_req_data;
        logic [3:0]  mem_req_strb;
        logic [3:0]  mem_req_id;
    } agu_pkg;

endpackage

// File: rtl/toy_lsu_stq_if.sv
// Store queue ports: AGU enqueue, ROB commit/cancel, memory drain, hazard view.
// Wires only; flow control is valid/ready on enqueue and drain.
interface toy_lsu_stq_if import toy_pack::*; #(parameter int DEPTH = STU_DEPTH) ();

    localparam int PTR_W = $clog2(DEPTH);

    logic                   cancel_en;
    logic                   s_st_req_vld;
    logic                   s_st_req_rdy;
    agu_pkg                 s_st_req_pld;
    logic                   st_commit_en;
    logic                   m_mem_req_vld;
    logic                   m_mem_req_rdy;
    agu_pkg                 m_mem_req_pld;
    logic [DEPTH-1:0]       v_stq_en;
    agu_pkg [DEPTH-1:0]     v_stq_pld;
    logic [PTR_W-1:0]       stq_wr_ptr;
    logic                   stq_full;
    logic                   stq_empty;

    modport slave (
        input  cancel_en, s_st_req_vld, s_st_req_pld, st_commit_en, m_mem_req_rdy,
        output s_st_req_rdy, m_mem_req_vld, m_mem_req_pld,
        output v_stq_en, v_stq_pld, stq_wr_ptr, stq_full, stq_empty
    );

    modport master (
        output cancel_en, s_st_req_vld, s_st_req_pld, st_commit_en, m_mem_req_rdy,
        input  s_st_req_rdy, m_mem_req_vld, m_mem_req_pld,
        input  v_stq_en, v_stq_pld, stq_wr_ptr, stq_full, stq_empty
    );

endinterface

// File: rtl/toy_lsu_stq_entry.sv
// One store queue slot: valid, committed flag and payload.
// Updates one cycle after its controls; no backpressure, the parent arbitrates.
module toy_lsu_stq_entry import toy_pack::*; (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   set_en,
    input  agu_pkg set_pld,
    input  logic   commit_en,
    input  logic   clear_en,
    input  logic   cancel_en,
    output logic   vld,
    output logic   cmt,
    output agu_pkg pld
);

    logic vld_nxt;
    logic cmt_nxt;

    // Commit is folded in before the cancel test so a same-cycle commit survives.
    always_comb begin
        vld_nxt = vld;
        cmt_nxt = cmt | commit_en;
        if (clear_en) begin
            vld_nxt = 1'b0;
            cmt_nxt = 1'b0;
        end
        if (set_en) begin
            vld_nxt = 1'b1;
            cmt_nxt = 1'b0;
        end
        if (cancel_en && !cmt_nxt) begin
            vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            cmt <= 1'b0;
            pld <= '0;
        end else begin
            vld <= vld_nxt;
            cmt <= cmt_nxt;
            if (set_en) begin
                pld <= set_pld;
            end
        end
    end

endmodule

// File: rtl/toy_lsu_stq.sv
// In-order store queue: buffers AGU stores, drains ROB-committed ones to memory.
// Enqueue visible next cycle; drain valid is registered state, independent of rdy.
// Backpressure: rdy low when full or cancelling; a drain frees a slot only next cycle.
module toy_lsu_stq import toy_pack::*; #(
    parameter int DEPTH = STU_DEPTH
) (
    input logic          clk,
    input logic          rst_n,
    toy_lsu_stq_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   cmt_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt_all;
    logic [CNT_W-1:0]   cnt_cmt;
    logic [DEPTH-1:0]   ent_vld;
    logic [DEPTH-1:0]   ent_cmt;
    agu_pkg [DEPTH-1:0] ent_pld;
    logic [DEPTH-1:0]   exp_vld;
    logic [DEPTH-1:0]   exp_cmt;

    logic               full;
    logic               enq;
    logic               cmt_ok;
    logic               drain;
    logic [PTR_W-1:0]   cmt_ptr_nxt;
    logic [CNT_W-1:0]   cnt_cmt_nxt;
    agu_pkg             mem_pld;

    assign full                = (cnt_all == CNT_W'(DEPTH));
    assign bus.stq_full        = full;
    assign bus.stq_empty       = (cnt_all == '0);
    assign bus.s_st_req_rdy    = ~full & ~bus.cancel_en;
    assign enq                 = bus.s_st_req_vld & bus.s_st_req_rdy;
    // A commit with nothing left to commit is dropped rather than corrupting cmt_ptr.
    assign cmt_ok              = bus.st_commit_en & (cnt_cmt != cnt_all);
    assign bus.m_mem_req_vld   = ent_vld[rd_ptr] & ent_cmt[rd_ptr];
    assign drain               = bus.m_mem_req_vld & bus.m_mem_req_rdy;
    assign cmt_ptr_nxt         = cmt_ptr + PTR_W'(cmt_ok);
    assign cnt_cmt_nxt         = cnt_cmt + CNT_W'(cmt_ok) - CNT_W'(drain);

    always_comb begin
        mem_pld                = ent_pld[rd_ptr];
        mem_pld.mem_req_opcode = TOY_BUS_WRITE;
    end
    assign bus.m_mem_req_pld   = mem_pld;

    assign bus.v_stq_en        = ent_vld;
    assign bus.v_stq_pld       = ent_pld;
    assign bus.stq_wr_ptr      = wr_ptr;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] off;

        toy_lsu_stq_entry u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .set_en    (enq    & (wr_ptr  == PTR_W'(i))),
            .set_pld   (bus.s_st_req_pld),
            .commit_en (cmt_ok & (cmt_ptr == PTR_W'(i))),
            .clear_en  (drain  & (rd_ptr  == PTR_W'(i))),
            .cancel_en (bus.cancel_en),
            .vld       (ent_vld[i]),
            .cmt       (ent_cmt[i]),
            .pld       (ent_pld[i])
        );

        // Distance from the oldest entry; drives the ordering invariant only.
        assign off        = PTR_W'(i) - rd_ptr;
        assign exp_vld[i] = CNT_W'(off) < cnt_all;
        assign exp_cmt[i] = CNT_W'(off) < cnt_cmt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
            cnt_all <= '0;
            cnt_cmt <= '0;
        end else begin
            rd_ptr  <= rd_ptr + PTR_W'(drain);
            cmt_ptr <= cmt_ptr_nxt;
            cnt_cmt <= cnt_cmt_nxt;
            if (bus.cancel_en) begin
                wr_ptr  <= cmt_ptr_nxt;
                cnt_all <= cnt_cmt_nxt;
            end else begin
                wr_ptr  <= wr_ptr + PTR_W'(enq);
                cnt_all <= cnt_all + CNT_W'(enq) - CNT_W'(drain);
            end
        end
    end

    a_cnt_order: assert property (@(posedge clk) disable iff (!rst_n) cnt_cmt <= cnt_all);
    a_commit_legal: assert property (@(posedge clk) disable iff (!rst_n)
        bus.st_commit_en |-> (cnt_cmt != cnt_all));
    a_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
        (ent_vld == exp_vld) && (ent_cmt == exp_cmt));

endmodule

// File: tb/tb_toy_lsu_stq.sv
// Bench for toy_lsu_stq: directed vector table, corner-case sequences, and a
// randomized run against a queue-based reference model.
module tb_toy_lsu_stq;
    import toy_pack::*;

    localparam int DEPTH = STU_DEPTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    toy_lsu_stq_if #(.DEPTH(DEPTH)) bus ();
    toy_lsu_stq #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        enq;
        logic [31:0] addr;
        logic        cmt;
        logic        rdy;
        logic        cxl;
        logic [7:0]  en;
        logic [2:0]  wp;
        logic        mvld;
        logic [31:0] maddr;
        logic        full;
        logic        empty;
        logic        srdy;
    } vec_t;

    vec_t   tv[$];
    agu_pkg q[$];
    int     ncmt;
    int     hd;
    int     sz;
    logic   r_vld, r_cmt, r_rdy, r_cxl, e_srdy, e_mvld;
    logic [DEPTH-1:0] e_en;
    agu_pkg r_pld;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic agu_pkg mk(input logic [31:0] a);
        agu_pkg p;
        p.mem_req_opcode = TOY_BUS_READ;
        p.mem_req_addr   = a;
        p.mem_req_data   = a ^ 32'hA5A5_0000;
        p.mem_req_strb   = 4'hF;
        p.mem_req_id     = a[5:2];
        return p;
    endfunction

    function automatic agu_pkg as_wr(input agu_pkg p);
        agu_pkg r;
        r = p;
        r.mem_req_opcode = TOY_BUS_WRITE;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.s_st_req_vld  = 1'b0;
        bus.s_st_req_pld  = '0;
        bus.st_commit_en  = 1'b0;
        bus.m_mem_req_rdy = 1'b0;
        bus.cancel_en     = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        #2;
        chk("rst_srdy",  128'(bus.s_st_req_rdy),  128'(1));
        chk("rst_mvld",  128'(bus.m_mem_req_vld), 128'(0));
        chk("rst_en",    128'(bus.v_stq_en),      128'(0));
        chk("rst_wp",    128'(bus.stq_wr_ptr),    128'(0));
        chk("rst_full",  128'(bus.stq_full),      128'(0));
        chk("rst_empty", 128'(bus.stq_empty),     128'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic rst, input logic enq, input logic [31:0] addr,
                       input logic cmt, input logic rdy, input logic cxl,
                       input logic [7:0] en, input logic [2:0] wp, input logic mvld,
                       input logic [31:0] maddr, input logic full, input logic empty,
                       input logic srdy);
        vec_t v;
        v = '{rst, enq, addr, cmt, rdy, cxl, en, wp, mvld, maddr, full, empty, srdy};
        tv.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();

        //   rst enq addr      cmt rdy cxl   en     wp  mvld maddr     full empty srdy
        add(1, 1, 32'h100, 0, 0, 0,  8'h00, 0, 0, 32'h0,   0, 1, 1);
        add(0, 1, 32'h104, 0, 0, 0,  8'h01, 1, 0, 32'h0,   0, 0, 1);
        add(0, 1, 32'h108, 0, 0, 0,  8'h03, 2, 0, 32'h0,   0, 0, 1);
        add(0, 0, 32'h0,   1, 1, 0,  8'h07, 3, 0, 32'h0,   0, 0, 1);
        add(0, 0, 32'h0,   1, 1, 0,  8'h07, 3, 1, 32'h100, 0, 0, 1);
        add(0, 0, 32'h0,   1, 1, 0,  8'h06, 3, 1, 32'h104, 0, 0, 1);
        add(0, 0, 32'h0,   0, 1, 0,  8'h04, 3, 1, 32'h108, 0, 0, 1);
        add(0, 0, 32'h0,   0, 0, 0,  8'h00, 3, 0, 32'h0,   0, 1, 1);
        add(1, 1, 32'h200, 0, 0, 0,  8'h00, 0, 0, 32'h0,   0, 1, 1);
        add(0, 1, 32'h204, 0, 0, 0,  8'h01, 1, 0, 32'h0,   0, 0, 1);
        add(0, 1, 32'h208, 0, 0, 0,  8'h03, 2, 0, 32'h0,   0, 0, 1);
        add(0, 1, 32'h20C, 0, 0, 0,  8'h07, 3, 0, 32'h0,   0, 0, 1);
        add(0, 1, 32'h210, 0, 0, 0,  8'h0F, 4, 0, 32'h0,   0, 0, 1);
        add(0, 0, 32'h0,   1, 0, 0,  8'h1F, 5, 0, 32'h0,   0, 0, 1);
        add(0, 0, 32'h0,   1, 0, 0,  8'h1F, 5, 1, 32'h200, 0, 0, 1);
        add(0, 1, 32'h2FF, 0, 0, 1,  8'h1F, 5, 1, 32'h200, 0, 0, 0);
        add(0, 1, 32'h300, 0, 0, 0,  8'h03, 2, 1, 32'h200, 0, 0, 1);
        add(0, 1, 32'h304, 0, 0, 0,  8'h07, 3, 1, 32'h200, 0, 0, 1);
        add(0, 0, 32'h0,   1, 0, 1,  8'h0F, 4, 1, 32'h200, 0, 0, 0);
        add(0, 0, 32'h0,   0, 0, 0,  8'h07, 3, 1, 32'h200, 0, 0, 1);
        add(0, 0, 32'h0,   0, 1, 0,  8'h07, 3, 1, 32'h200, 0, 0, 1);
        add(0, 0, 32'h0,   0, 1, 0,  8'h06, 3, 1, 32'h204, 0, 0, 1);
        add(0, 0, 32'h0,   0, 1, 0,  8'h04, 3, 1, 32'h300, 0, 0, 1);
        add(0, 0, 32'h0,   0, 0, 0,  8'h00, 3, 0, 32'h0,   0, 1, 1);

        foreach (tv[k]) begin
            if (tv[k].rst) do_reset();
            bus.s_st_req_vld  = tv[k].enq;
            bus.s_st_req_pld  = mk(tv[k].addr);
            bus.st_commit_en  = tv[k].cmt;
            bus.m_mem_req_rdy = tv[k].rdy;
            bus.cancel_en     = tv[k].cxl;
            #1;
            chk($sformatf("v%0d_en", k),    128'(bus.v_stq_en),      128'(tv[k].en));
            chk($sformatf("v%0d_wp", k),    128'(bus.stq_wr_ptr),    128'(tv[k].wp));
            chk($sformatf("v%0d_mvld", k),  128'(bus.m_mem_req_vld), 128'(tv[k].mvld));
            chk($sformatf("v%0d_full", k),  128'(bus.stq_full),      128'(tv[k].full));
            chk($sformatf("v%0d_empty", k), 128'(bus.stq_empty),     128'(tv[k].empty));
            chk($sformatf("v%0d_srdy", k),  128'(bus.s_st_req_rdy),  128'(tv[k].srdy));
            if (tv[k].mvld)
                chk($sformatf("v%0d_mpld", k), 128'(bus.m_mem_req_pld), 128'(as_wr(mk(tv[k].maddr))));
            step();
        end

        // Full queue, drain one: rdy must not bypass in the drain cycle, then wraps to entry 0.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            bus.s_st_req_vld = 1'b1;
            bus.s_st_req_pld = mk(32'h400 + 32'(4 * k));
            step();
        end
        idle_in();
        #1;
        chk("fill_full", 128'(bus.stq_full),     128'(1));
        chk("fill_srdy", 128'(bus.s_st_req_rdy), 128'(0));
        chk("fill_wp",   128'(bus.stq_wr_ptr),   128'(0));
        chk("fill_en",   128'(bus.v_stq_en),     128'(8'hFF));
        bus.st_commit_en = 1'b1;
        step();
        bus.st_commit_en  = 1'b0;
        bus.m_mem_req_rdy = 1'b1;
        bus.s_st_req_vld  = 1'b1;
        bus.s_st_req_pld  = mk(32'h500);
        #1;
        chk("wrap_mvld",     128'(bus.m_mem_req_vld), 128'(1));
        chk("wrap_nobypass", 128'(bus.s_st_req_rdy),  128'(0));
        step();
        bus.m_mem_req_rdy = 1'b0;
        #1;
        chk("wrap_srdy", 128'(bus.s_st_req_rdy), 128'(1));
        chk("wrap_full", 128'(bus.stq_full),     128'(0));
        step();
        bus.s_st_req_vld = 1'b0;
        #1;
        chk("wrap_wp",   128'(bus.stq_wr_ptr),   128'(1));
        chk("wrap_en",   128'(bus.v_stq_en),     128'(8'hFF));
        chk("wrap_pld0", 128'(bus.v_stq_pld[0]), 128'(mk(32'h500)));

        // Back-pressure: held 4 cycles with a stable payload, then one drain per cycle.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.s_st_req_vld = 1'b1;
            bus.s_st_req_pld = mk(32'h600 + 32'(4 * k));
            step();
        end
        bus.s_st_req_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.st_commit_en = 1'b1;
            step();
        end
        bus.st_commit_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_hold%0d_vld", k), 128'(bus.m_mem_req_vld), 128'(1));
            chk($sformatf("bp_hold%0d_pld", k), 128'(bus.m_mem_req_pld), 128'(as_wr(mk(32'h600))));
            step();
        end
        bus.m_mem_req_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_drain%0d_vld", k), 128'(bus.m_mem_req_vld), 128'(1));
            chk($sformatf("bp_drain%0d_pld", k), 128'(bus.m_mem_req_pld),
                128'(as_wr(mk(32'h600 + 32'(4 * k)))));
            step();
        end
        bus.m_mem_req_rdy = 1'b0;
        #1;
        chk("bp_done_vld",   128'(bus.m_mem_req_vld), 128'(0));
        chk("bp_done_empty", 128'(bus.stq_empty),     128'(1));

        // Randomized traffic against an in-order queue model; head index tracks slot placement.
        do_reset();
        q.delete();
        ncmt = 0;
        hd   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                do_reset();
                q.delete();
                ncmt = 0;
                hd   = 0;
            end
            sz    = q.size();
            r_vld = ($urandom_range(0, 9) < 6);
            r_cmt = (ncmt < sz) && ($urandom_range(0, 9) < 4);
            r_rdy = ($urandom_range(0, 9) < 6);
            r_cxl = ($urandom_range(0, 19) == 0);
            r_pld.mem_req_opcode = toy_bus_op_e'($urandom_range(0, 3));
            r_pld.mem_req_addr   = $urandom;
            r_pld.mem_req_data   = $urandom;
            r_pld.mem_req_strb   = 4'($urandom);
            r_pld.mem_req_id     = 4'($urandom);
            bus.s_st_req_vld  = r_vld;
            bus.s_st_req_pld  = r_pld;
            bus.st_commit_en  = r_cmt;
            bus.m_mem_req_rdy = r_rdy;
            bus.cancel_en     = r_cxl;
            #1;

            e_srdy = (sz != DEPTH) && !r_cxl;
            e_mvld = (ncmt > 0);
            e_en   = '0;
            for (int k = 0; k < sz; k++) e_en[(hd + k) % DEPTH] = 1'b1;
            chk("rnd_srdy",  128'(bus.s_st_req_rdy),  128'(e_srdy));
            chk("rnd_mvld",  128'(bus.m_mem_req_vld), 128'(e_mvld));
            chk("rnd_en",    128'(bus.v_stq_en),      128'(e_en));
            chk("rnd_wp",    128'(bus.stq_wr_ptr),    128'((hd + sz) % DEPTH));
            chk("rnd_full",  128'(bus.stq_full),      128'(sz == DEPTH));
            chk("rnd_empty", 128'(bus.stq_empty),     128'(sz == 0));
            if (e_mvld) chk("rnd_mpld", 128'(bus.m_mem_req_pld), 128'(as_wr(q[0])));
            for (int k = 0; k < sz; k++)
                chk("rnd_vpld", 128'(bus.v_stq_pld[(hd + k) % DEPTH]), 128'(q[k]));

            if (r_cmt) ncmt++;
            if (e_mvld && r_rdy) begin
                void'(q.pop_front());
                ncmt--;
                hd = (hd + 1) % DEPTH;
            end
            if (r_cxl) begin
                while (q.size() > ncmt) void'(q.pop_back());
            end
            if (r_vld && e_srdy) q.push_back(r_pld);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toy_lsu_stq.md
Name: toy_lsu_stq

Overview:
Store queue for the toy LSU. It sits upstream of the load hazard checker and downstream of the store AGU. It buffers store requests in program order and tracks which entries have been committed by the ROB. It drains committed stores in order to the memory bus, and exposes all entries (valid vector, payloads, write pointer) for load-to-store address/strobe hazard checks and data forwarding. On cancel it drops every uncommitted entry.

Parameters:
DEPTH, STU_DEPTH (8), number of entries; must be a power of 2, >= 2.
PTR_W, $clog2(DEPTH), entry index width (derived localparam, not overridable).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cancel_en  input  1  pipeline flush; drops uncommitted entries
s_st_req_vld  input  1  store request from AGU valid
s_st_req_rdy  output  1  queue can accept a store
s_st_req_pld  input  agu_pkg  store addr/data/strb/sideband
st_commit_en  input  1  ROB commits the oldest uncommitted store (one per cycle)
m_mem_req_vld  output  1  committed store ready to drain
m_mem_req_rdy  input  1  memory bus accepts
m_mem_req_pld  output  agu_pkg  drained store, opcode forced to TOY_BUS_WRITE
v_stq_en  output  DEPTH  per-entry valid (committed or not)
v_stq_pld  output  agu_pkg[DEPTH]  per-entry payload
stq_wr_ptr  output  PTR_W  next allocation index (youngest entry = stq_wr_ptr-1, modulo DEPTH)
stq_full  output  1  all DEPTH entries valid
stq_empty  output  1  no valid entries

Behaviour:
- State: wr_ptr, cmt_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH). Separate cnt_all (0..DEPTH) and cnt_cmt (0..DEPTH), each PTR_W+1 bits. Per-entry vld, cmt, and payload regs.
- Reset: all pointers and counters 0; vld/cmt all 0; payload regs 0. Outputs: s_st_req_rdy=1, m_mem_req_vld=0, v_stq_en=0, stq_wr_ptr=0, stq_full=0, stq_empty=1.
- Enqueue: s_st_req_rdy = ~stq_full & ~cancel_en. On vld&rdy, write the payload to entry[wr_ptr], set vld and clear cmt, then wr_ptr++ (wrap DEPTH-1 -> 0). The entry is visible on v_stq_en/v_stq_pld the next cycle.
- No same-cycle bypass: when full, a drain in the same cycle does not raise rdy. Rdy rises the cycle after the free.
- Commit: st_commit_en sets cmt[cmt_ptr] and does cmt_ptr++. Commit with no uncommitted valid entry is illegal (assertion); the RTL ignores it.
- Drain: m_mem_req_vld = vld[rd_ptr] & cmt[rd_ptr], a registered-state function with no dependence on rdy. m_mem_req_pld = entry[rd_ptr], with mem_req_opcode = TOY_BUS_WRITE and all other fields passed through.
- On vld&rdy: clear vld/cmt of entry[rd_ptr] and do rd_ptr++. The payload is held stable while vld&~rdy.
- Cancel (cancel_en=1):
  - Clear vld of every entry with cmt=0.
  - wr_ptr <= cmt_ptr (after any same-cycle commit advance).
  - cnt_all <= cnt_cmt (after same-cycle commit and drain adjustments).
  - Committed entries and the drain stream are unaffected.
  - The enqueue handshake is blocked that cycle.
- Simultaneous events:
  - Commit + cancel: the commit takes effect first, so the just-committed entry survives.
  - Drain + cancel: the drain completes normally.
  - Enqueue + drain: cnt_all unchanged.
  - Commit + drain: cnt_cmt unchanged.
- Counters:
  - cnt_all += enq - drain.
  - cnt_cmt += commit - drain.
  - stq_full = (cnt_all==DEPTH); stq_empty = (cnt_all==0).
- Invariants (assertions):
  - cnt_cmt <= cnt_all.
  - Valid entries are contiguous from rd_ptr.
  - Committed entries are a prefix of the valid entries.
- Reset mid-operation: asynchronous; all state is cleared immediately, and any in-flight bus request is dropped.

Decomposition:
- toy_pack (existing) supplies STU_DEPTH, agu_pkg, and TOY_BUS_WRITE. No new typedefs are needed.
- One natural sub-module: toy_lsu_stq_entry, a single entry holding vld/cmt/payload with set/commit/clear/cancel controls, instantiated DEPTH times by generate.
- Pointer and counter logic stays in the top level.

Test Plan:
- Reset then 3 enqueues (addr 0x100/0x104/0x108): v_stq_en=0b0000_0111, stq_wr_ptr=3, m_mem_req_vld=0 until commit.
- 3 commits, m_mem_req_rdy=1: drains in order 0x100, 0x104, 0x108 with opcode TOY_BUS_WRITE on 3 consecutive cycles; then stq_empty=1.
- Fill 8 entries: stq_full=1, s_st_req_rdy=0. Commit and drain one with rdy=1: rdy=1 the next cycle, and the 9th enqueue lands in entry 0 (wrap) with stq_wr_ptr=1.
- 5 enqueued, 2 committed, cancel_en pulse: v_stq_en=0b0000_0011, stq_wr_ptr=2. The next enqueue goes to entry 2.
- Cancel in the same cycle as the 3rd commit, with 4 entries: 3 entries survive, stq_wr_ptr=3, cnt_all=3.
- Back-pressure: m_mem_req_rdy=0 for 4 cycles: vld stays 1 and the payload is held stable. Then rdy=1 gives exactly one drain per cycle.
